// File: rtl/timer_defs.sv
// Shared register map and CTRL bit positions for the timer bank.
package timer_defs;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    localparam int EN_BIT = 31;
    localparam int OS_BIT = 30;
    localparam int IE_BIT = 29;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PERIOD/COUNT/STATUS registers, prescaler and wrap logic.
module timer_channel
    import timer_defs::*;
#(
    parameter int CNT_W   = 16,
    parameter int SCALE_W = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [1:0]         reg_sel,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               irq
);

    logic               en_reg;
    logic               os_reg;
    logic               ie_reg;
    logic [SCALE_W-1:0] scale_reg;
    logic [SCALE_W-1:0] pre_reg;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               sticky_reg;
    logic               ovf_reg;

    reg_e sel;
    logic tick;
    logic wrap;
    logic wr_ctrl;
    logic wr_period;
    logic wr_status;
    logic unused_wdata;

    assign sel       = reg_e'(reg_sel);
    assign tick      = en_reg && (pre_reg == scale_reg);
    // >= rather than == so a PERIOD rewritten below the count wraps at once
    assign wrap      = tick && (count_reg >= period_reg);
    assign wr_ctrl   = we && (sel == REG_CTRL);
    assign wr_period = we && (sel == REG_PERIOD);
    assign wr_status = we && (sel == REG_STATUS);
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_reg     <= 1'b0;
            os_reg     <= 1'b0;
            ie_reg     <= 1'b0;
            scale_reg  <= '0;
            pre_reg    <= '0;
            period_reg <= '0;
            count_reg  <= '0;
            sticky_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            ovf_reg <= wrap;

            if (!en_reg) begin
                pre_reg   <= '0;
                count_reg <= '0;
            end else if (tick) begin
                pre_reg   <= '0;
                count_reg <= wrap ? '0 : count_reg + 1'b1;
            end else begin
                pre_reg   <= pre_reg + 1'b1;
            end

            if (wrap && os_reg)
                en_reg <= 1'b0;

            // A CTRL write lands after the one-shot clear so the written en wins
            if (wr_ctrl) begin
                en_reg    <= wdata[EN_BIT];
                os_reg    <= wdata[OS_BIT];
                ie_reg    <= wdata[IE_BIT];
                scale_reg <= wdata[SCALE_W-1:0];
            end

            if (wr_period)
                period_reg <= wdata[CNT_W-1:0];

            if (wrap)
                sticky_reg <= 1'b1;
            else if (wr_status && wdata[0])
                sticky_reg <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL: begin
                rdata[EN_BIT]        = en_reg;
                rdata[OS_BIT]        = os_reg;
                rdata[IE_BIT]        = ie_reg;
                rdata[SCALE_W-1:0]   = scale_reg;
            end
            REG_PERIOD: rdata[CNT_W-1:0] = period_reg;
            REG_COUNT:  rdata[CNT_W-1:0] = count_reg;
            REG_STATUS: rdata[0]         = sticky_reg;
            default:    rdata = '0;
        endcase
    end

    assign count    = count_reg;
    assign overflow = ovf_reg;
    assign irq      = sticky_reg & ie_reg;

endmodule

// File: rtl/timer_bank.sv
// N-channel memory-mapped timer bank: address decode, read mux, count packing, irq merge.
module timer_bank
    import timer_defs::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int SCALE_W = 15,
    localparam int AW     = $clog2(N_CH) + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    output logic [N_CH-1:0]         overflow,
    output logic [N_CH*CNT_W-1:0]   cntr,
    output logic                    irq
);

    logic [31:0]     ch_idx;
    logic [N_CH-1:0] ch_we;
    logic [N_CH-1:0] ch_irq;
    logic [31:0]     ch_rd [N_CH];

    // Shift keeps this valid for N_CH=1, where addr has no channel field
    assign ch_idx = 32'(addr) >> 2;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_we[gi] = we && (ch_idx == 32'(gi));

            timer_channel #(
                .CNT_W   (CNT_W),
                .SCALE_W (SCALE_W)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .we       (ch_we[gi]),
                .reg_sel  (addr[1:0]),
                .wdata    (wdata),
                .rdata    (ch_rd[gi]),
                .count    (cntr[gi*CNT_W +: CNT_W]),
                .overflow (overflow[gi]),
                .irq      (ch_irq[gi])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == 32'(i))
                rdata = ch_rd[i];
        end
    end

    assign irq = |ch_irq;

endmodule
